mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Multi-cycle load/store engine for the multi-cycle MIPS CPU. Sits directly downstream of the ALU-output address register.
- Takes the registered effective address plus store data and size from the control FSM, and drives the synchronous data memory with byte enables.
- Returns aligned, sign- or zero-extended load data with a one-cycle done pulse.
- Handles LB/LBU/LH/LHU/LW/SB/SH/SW for the control unit.

Parameters:
ADDR_W, 8, word-address width of data memory (mem_addr = addr[ADDR_W+1:2])
WAIT_CYCLES, 0, extra memory wait cycles inserted after the access cycle (0..15)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  1  start request, sampled only in IDLE
we  in  1  1=store, 0=load
size  in  2  00 byte, 01 half, 10 word, 11 treated as word
sign_ext  in  1  loads only: 1 sign-extend, 0 zero-extend
addr  in  32  byte address from address register
wdata  in  32  store data (low bits used for byte/half)
busy  out  1  high while a request is in flight
done  out  1  one-cycle completion pulse
rdata  out  32  formatted load result, held until next load completes
err  out  1  misalignment flag, pulses with done
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_be  out  4  byte enables, bit0 = bits 7:0
mem_addr  out  ADDR_W  word address
mem_wdata  out  32  lane-replicated store data
mem_rdata  in  32  memory read data, valid the cycle after last access/wait cycle

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, err, mem_en, mem_we = 0; mem_be=0; rdata=0; captured addr/wdata/size/we/sign_ext registers = 0.
- FSM states: IDLE, ACCESS, WAIT, CAPTURE.
- IDLE: when req=1, capture addr, we, size, sign_ext and wdata at the edge, then go to ACCESS. req=0: stay.
- ACCESS (1 cycle): mem_en=1, mem_we=captured we, mem_be/mem_addr/mem_wdata driven from captured values. Next state: WAIT with counter=WAIT_CYCLES-1 if WAIT_CYCLES>0, else CAPTURE.
- WAIT: mem_en=0. Decrement counter; go to CAPTURE at 0.
- CAPTURE (1 cycle): mem_rdata valid. At the closing edge:
  - loads: rdata <= formatted data;
  - all requests: done <= 1;
  - next state IDLE.
- done is high for exactly the first IDLE cycle after CAPTURE. A req in that cycle is accepted (back-to-back).
- Latency from req edge to done high is WAIT_CYCLES+3 cycles, identical for loads and stores.
- busy=1 in ACCESS, WAIT and CAPTURE. req while busy is ignored and not queued.
- mem_en, mem_we, mem_be are registered or state-decoded only, never combinational from req.
- Store lanes, little-endian, a=addr[1:0]:
  - byte: be=0001<<a, mem_wdata={4{wdata[7:0]}};
  - half: be=0011<<{a[1],0}, mem_wdata={2{wdata[15:0]}};
  - word: be=1111, mem_wdata=wdata.
- mem_be=0 on loads.
- Load formatting:
  - byte: select lane a;
  - half: select lane a[1];
  - extend to 32 per sign_ext;
  - word: pass through unchanged.
- Misaligned: half with a[0]=1, or word with a!=00. Handling is per Optional Feature.
- Reset mid-operation aborts immediately: mem_en/mem_we drop asynchronously, no done, rdata=0.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - a misaligned request still walks ACCESS/WAIT/CAPTURE with the same latency;
  - mem_en=0 and mem_we=0 throughout;
  - rdata is not updated;
  - err=1 in the same cycle as done.
- Undefined:
  - ignored low address bits are treated as zero (half: a[0]; word: a[1:0]);
  - the access is performed aligned;
  - err is tied 0.
- The err port exists in both builds.

Test Plan:
- Reset with rst_n=0 mid-ACCESS of a store -> mem_en/mem_we drop immediately; all outputs 0; after release, req is accepted normally.
- WAIT_CYCLES=0: LW addr=0x10, mem word1... word4=0x8899AABB -> mem_addr=4, mem_en one cycle, done 3 cycles after req, rdata=0x8899AABB.
- LB addr=0x13 sign_ext=1 -> rdata=0xFFFFFF88. Same request with sign_ext=0 -> 0x00000088. LH addr=0x12 sign_ext=1 -> 0xFFFF8899.
- SH addr=0x06 wdata=0x00001234 -> mem_addr=1, mem_be=1100, mem_wdata=0x12341234, mem_we=1 for one cycle. SB addr=0x05 wdata=0xAB -> mem_be=0010, mem_wdata=0xABABABAB.
- WAIT_CYCLES=2: LW -> done 5 cycles after req. A second req pulsed during WAIT is ignored. A req in the done cycle starts the next access immediately.
- LW addr=0x02:
  - with MISALIGN_TRAP_EN -> no mem_en, err=1 with done, rdata unchanged;
  - without it -> reads word address 0, err=0.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle load/store engine for the data memory.
// Define MISALIGN_TRAP_EN to suppress misaligned accesses and flag them on err.
module mem_access_unit #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, WAIT = 2'd2, CAPTURE = 2'd3;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [31:0] a_addr, a_wdata;
    logic        a_we, a_sext;
    logic [1:0]  a_size, a;
    logic        trap, acc;
    logic [7:0]  bsel;
    logic [15:0] hsel;
    logic [31:0] fmt;
    logic [3:0]  be;
    logic        unused_addr_bits;
    assign a = a_addr[1:0];
    assign unused_addr_bits = ^a_addr[31:ADDR_W+2];
`ifdef MISALIGN_TRAP_EN
    assign trap = (a_size == 2'b01) ? a[0] : (a_size[1] && a != 2'b00);
`else
    assign trap = 1'b0;
`endif
    // Strobes are decoded from state so an async reset drops them at once
    assign acc       = (state == ACCESS) && !trap;
    assign busy      = state != IDLE;
    assign mem_en    = acc;
    assign mem_we    = acc && a_we;
    assign mem_be    = (acc && a_we) ? be : 4'b0000;
    assign mem_addr  = a_addr[ADDR_W+1:2];
    assign be        = (a_size == 2'b00) ? 4'b0001 << a :
                       (a_size == 2'b01) ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign mem_wdata = (a_size == 2'b00) ? {4{a_wdata[7:0]}} :
                       (a_size == 2'b01) ? {2{a_wdata[15:0]}} : a_wdata;
    assign bsel = a[1] ? (a[0] ? mem_rdata[31:24] : mem_rdata[23:16])
                       : (a[0] ? mem_rdata[15:8] : mem_rdata[7:0]);
    assign hsel = a[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    assign fmt  = (a_size == 2'b00) ? {{24{a_sext & bsel[7]}}, bsel} :
                  (a_size == 2'b01) ? {{16{a_sext & hsel[15]}}, hsel} : mem_rdata;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            done    <= 1'b0;
            err     <= 1'b0;
            rdata   <= 32'd0;
            a_addr  <= 32'd0;
            a_wdata <= 32'd0;
            a_we    <= 1'b0;
            a_sext  <= 1'b0;
            a_size  <= 2'b00;
        end else begin
            done <= state == CAPTURE;
            err  <= (state == CAPTURE) && trap;
            if (state == IDLE && req) begin
                a_addr  <= addr;
                a_wdata <= wdata;
                a_we    <= we;
                a_sext  <= sign_ext;
                a_size  <= size;
                state   <= ACCESS;
            end else if (state == ACCESS) begin
                state <= (WAIT_CYCLES > 0) ? WAIT : CAPTURE;
                cnt   <= CNT_INIT;
            end else if (state == WAIT) begin
                state <= (cnt == 4'd0) ? CAPTURE : WAIT;
                cnt   <= cnt - 4'd1;
            end else if (state == CAPTURE) begin
                if (!a_we && !trap) rdata <= fmt;
                state <= IDLE;
            end
        end
    end
endmodule
